// File: rtl/sampler.sv
// Gated ADC sample capture with integer decimation and a ready/valid
// drain toward a UART-style transmitter.  One capture per arm request:
// the gate's rising edge starts the capture, gate low or a full buffer
// ends it, and the stored samples are then streamed out oldest first.
module sampler #(
    parameter int DATA_SIZE    = 8,
    parameter int BUFFER_DEPTH = 256
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_adc_init,
    input  logic                 i_gate,
    input  logic                 i_sample,
    input  logic                 i_cmd_decim,
    input  logic [3:0]           i_cmd_param,
    input  logic                 i_next,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_idle
);

    localparam int AW    = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SEND} state_t;

    state_t               state_q, state_d;
    logic                 gate_q;
    logic [3:0]           decim_q, decim_d;
    logic [3:0]           phase_q, phase_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DATA_SIZE-1:0] mem [BUFFER_DEPTH];

    logic                 gate_rise;
    logic [3:0]           phase_step;

    assign gate_rise  = i_gate & ~gate_q;
    // Decimation phase advances modulo R = P+1; phase 0 is a write slot.
    assign phase_step = (phase_q == decim_q) ? 4'd0 : phase_q + 4'd1;

    // Next-state, buffer write control and output stream logic.
    always_comb begin
        state_d  = state_q;
        decim_d  = decim_q;
        phase_d  = phase_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_en    = 1'b0;
        wr_addr  = count_q[AW-1:0];

        case (state_q)
            IDLE: begin
                phase_d = 4'd0;
                if (i_cmd_decim) begin
                    decim_d = i_cmd_param;
                end
                if (i_sample && i_adc_init) begin
                    state_d  = ARMED;
                    count_d  = '0;
                    rd_ptr_d = '0;
                end
            end
            ARMED: begin
                if (!i_adc_init) begin
                    state_d = IDLE;
                end else if (gate_rise) begin
                    // The edge sample itself is the first write (phase 0).
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = CNT_W'(1);
                    phase_d = phase_step;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!i_adc_init) begin
                    state_d = IDLE;
                end else if (!i_gate || count_q == FULL) begin
                    state_d  = SEND;
                    rd_ptr_d = '0;
                end else begin
                    if (phase_q == 4'd0) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                    phase_d = phase_step;
                end
            end
            SEND: begin
                // Load a new word when the output slot is empty or just taken.
                if (!valid_q || i_next) begin
                    if (rd_ptr_q != count_q) begin
                        data_d   = mem[rd_ptr_q[AW-1:0]];
                        valid_d  = 1'b1;
                        rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            gate_q   <= 1'b0;
            decim_q  <= 4'd0;
            phase_q  <= 4'd0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gate_q   <= i_gate;
            decim_q  <= decim_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Capture buffer write port; contents need no reset.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= i_data;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_idle  = (state_q == IDLE);

endmodule

// File: tb/tb_sampler.sv
// Directed bench for sampler: capture, decimation, back-pressure,
// buffer-full, abort and reset-during-send scenarios.
module tb_sampler;

    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [DW-1:0] din;
    logic          i_adc_init;
    logic          i_gate;
    logic          i_sample;
    logic          i_cmd_decim;
    logic [3:0]    i_cmd_param;
    logic          i_next;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_idle;

    always #5 clk = ~clk;

    sampler #(.DATA_SIZE(DW), .BUFFER_DEPTH(DEPTH)) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_data      (din),
        .i_adc_init  (i_adc_init),
        .i_gate      (i_gate),
        .i_sample    (i_sample),
        .i_cmd_decim (i_cmd_decim),
        .i_cmd_param (i_cmd_param),
        .i_next      (i_next),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_idle      (o_idle)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] v;
    logic [DW-1:0] hold;

    // Transfer monitor: a word moves on the next rising edge.
    always @(negedge clk) begin
        if (i_reset && o_valid && i_next) got.push_back(o_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        din = din + 8'd1;
    endtask

    task automatic arm();
        i_sample = 1'b1;
        tick();
        i_sample = 1'b0;
    endtask

    task automatic set_decim(input logic [3:0] p);
        i_cmd_decim = 1'b1;
        i_cmd_param = p;
        tick();
        i_cmd_decim = 1'b0;
    endtask

    task automatic capture(input int n, output logic [DW-1:0] first);
        i_gate = 1'b1;
        first  = din;
        repeat (n) tick();
        i_gate = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_idle && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(o_idle), 32'd1);
    endtask

    task automatic check_seq(input string tag, input logic [DW-1:0] first,
                             input int step, input int cnt);
        logic [DW-1:0] e;
        check({tag, "_count"}, 32'(got.size()), 32'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (k < got.size()) begin
                e = first + DW'(k * step);
                check(tag, 32'(got[k]), 32'(e));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset     = 1'b0;
        din         = '0;
        i_adc_init  = 1'b0;
        i_gate      = 1'b0;
        i_sample    = 1'b0;
        i_cmd_decim = 1'b0;
        i_cmd_param = 4'd0;
        i_next      = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_idle",  32'(o_idle),  32'd1);
        check("rst_data",  32'(o_data),  32'd0);
        i_reset    = 1'b1;
        i_adc_init = 1'b1;
        tick();

        // R=1, ten samples; a decimation strobe while armed must be ignored.
        got.delete();
        arm();
        set_decim(4'd3);
        tick();
        capture(10, v);
        wait_idle("r1_idle", 100);
        check_seq("r1", v, 1, 10);

        // P=3 -> R=4: samples v, v+4, v+8.
        set_decim(4'd3);
        got.delete();
        arm();
        tick();
        capture(10, v);
        wait_idle("r4_idle", 100);
        check_seq("r4", v, 4, 3);
        set_decim(4'd0);

        // Back-pressure for five cycles mid-stream.
        got.delete();
        arm();
        tick();
        capture(10, v);
        for (int n = 0; n < 20 && !o_valid; n++) tick();
        tick();
        tick();
        i_next = 1'b0;
        hold   = o_data;
        repeat (5) begin
            tick();
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_data",  32'(o_data),  32'(hold));
        end
        i_next = 1'b1;
        wait_idle("stall_idle", 100);
        check_seq("stall", v, 1, 10);

        // Gate held 300 cycles: buffer fills at 256 and sending starts early.
        got.delete();
        arm();
        tick();
        capture(300, v);
        check("depth_early_send", 32'(got.size() > 30), 32'd1);
        wait_idle("depth_idle", 400);
        check_seq("depth", v, 1, DEPTH);

        // Arm request while the ADC is not ready is ignored.
        i_adc_init = 1'b0;
        i_sample   = 1'b1;
        tick();
        i_sample = 1'b0;
        tick();
        check("noarm_idle", 32'(o_idle), 32'd1);

        // ADC ready dropped during capture aborts with no output.
        i_adc_init = 1'b1;
        got.delete();
        arm();
        tick();
        i_gate = 1'b1;
        repeat (3) tick();
        i_adc_init = 1'b0;
        tick();
        check("abort_idle", 32'(o_idle), 32'd1);
        repeat (5) begin
            tick();
            check("abort_valid", 32'(o_valid), 32'd0);
        end
        i_gate     = 1'b0;
        i_adc_init = 1'b1;
        tick();
        check("abort_none", 32'(got.size()), 32'd0);

        // Gate already high when armed: wait for the next rising edge.
        got.delete();
        i_gate = 1'b1;
        tick();
        arm();
        repeat (5) tick();
        check("prehigh_armed", 32'(o_idle), 32'd0);
        check("prehigh_none",  32'(got.size()), 32'd0);
        i_gate = 1'b0;
        tick();
        capture(2, v);
        wait_idle("prehigh_idle", 100);
        check_seq("prehigh", v, 1, 2);

        // Reset held two cycles while a word is stalled in SEND.
        got.delete();
        i_next = 1'b0;
        arm();
        tick();
        capture(10, v);
        repeat (4) tick();
        check("send_valid", 32'(o_valid), 32'd1);
        check("send_first", 32'(o_data),  32'(v));
        i_reset = 1'b0;
        tick();
        tick();
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_idle",  32'(o_idle),  32'd1);
        check("midrst_data",  32'(o_data),  32'd0);
        i_reset = 1'b1;
        i_next  = 1'b1;
        repeat (5) tick();
        check("midrst_none",  32'(got.size()), 32'd0);
        check("midrst_quiet", 32'(o_valid),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sampler.md
SAMPLER -- requirements
Module: sampler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, sample/output word width in bits.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 256, capture buffer depth in samples (power of two, >=2).
REQ-003 SHALL have port i_clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous active-low reset.
REQ-005 SHALL have port i_data  input  DATA_SIZE  ADC sample bus, valid every cycle.
REQ-006 SHALL have port i_adc_init  input  1  ADC ready/enable; high allows arming and capture.
REQ-007 SHALL have port i_gate  input  1  external capture gate.
REQ-008 SHALL have port i_sample  input  1  one-cycle arm request.
REQ-009 SHALL have port i_cmd_decim  input  1  one-cycle strobe loading the decimation setting.
REQ-010 SHALL have port i_cmd_param  input  4  decimation setting P; capture ratio R = P+1 (1..16).
REQ-011 SHALL have port i_next  input  1  downstream ready (UART transmitter tready).
REQ-012 SHALL have port o_data  output  DATA_SIZE  sample presented downstream.
REQ-013 SHALL have port o_valid  output  1  o_data valid; a transfer occurs on a cycle with o_valid=1 and i_next=1.
REQ-014 SHALL have port o_idle  output  1  high only in state IDLE.

Function
REQ-015 SHALL implement states IDLE, ARMED, CAPTURE, SEND.
REQ-016 SHALL register i_gate each cycle (gate_d); rising edge = i_gate=1 and gate_d=0.
REQ-017 IDLE: i_sample=1 with i_adc_init=1 SHALL go to ARMED next cycle and clear write pointer/count; i_sample with i_adc_init=0 SHALL be ignored.
REQ-018 IDLE: i_cmd_decim=1 SHALL load P from i_cmd_param; strobes outside IDLE SHALL be ignored; ratio applies from the next capture.
REQ-019 ARMED: on gate rising edge, SHALL write i_data to buffer[0] that same cycle and enter CAPTURE; a gate already high on arming SHALL wait for the next rising edge.
REQ-020 CAPTURE: a modulo-R counter SHALL restart at 0 on the edge sample; i_data SHALL be written on every cycle with i_gate=1 and counter=0, so N gate-high cycles yield ceil(N/R) samples, one per R cycles.
REQ-021 CAPTURE SHALL end and enter SEND on the first cycle with i_gate=0 (no write that cycle) or when count reaches BUFFER_DEPTH (even with gate still high).
REQ-022 ARMED/CAPTURE: i_adc_init=0 SHALL abort to IDLE, discarding captured data, no output.
REQ-023 i_sample in any state other than IDLE SHALL be ignored.
REQ-024 SEND: o_valid SHALL rise no later than 2 cycles after entering SEND; samples SHALL be presented in capture order, oldest first.
REQ-025 o_data and o_valid SHALL stay stable while o_valid=1 and i_next=0; after each transfer the next sample SHALL be presented within 1 cycle with no sample dropped or duplicated.
REQ-026 After the last transfer o_valid SHALL fall the next cycle and the FSM SHALL return to IDLE; i_adc_init and i_gate SHALL be ignored in SEND.
REQ-027 Sample count width SHALL be clog2(BUFFER_DEPTH)+1; pointers SHALL not wrap within one capture.
REQ-028 o_data SHALL hold its last value when o_valid=0.

Reset
REQ-029 With i_reset=0 at a clock edge: state IDLE, o_valid=0, o_data=0, o_idle=1, P=0 (R=1), gate_d=0, pointers/counts 0; reset SHALL override any operation in progress, including mid-SEND.

Verification
REQ-030 Hold i_reset=0 two cycles mid-SEND -> o_valid=0, o_idle=1, o_data=0 next cycle; no further transfers.
REQ-031 R=1, i_next=1, i_data incrementing by 1 per cycle, arm, gate high 10 cycles with i_data=v at edge -> exactly 10 transfers v..v+9, then o_idle=1.
REQ-032 i_cmd_decim with i_cmd_param=3 in IDLE, same gate -> 3 transfers v, v+4, v+8.
REQ-033 During SEND, i_next=0 for 5 cycles -> o_data/o_valid unchanged; all 10 samples still delivered once each, in order.
REQ-034 BUFFER_DEPTH=256, gate high 300 cycles -> SEND starts after 256 writes while gate high; 256 transfers.
REQ-035 i_sample with i_adc_init=0 -> stays IDLE; i_adc_init dropped in CAPTURE -> IDLE, o_valid never rises.
